dm_stage: RTL and testbench

//  Data-memory stage of the 5-stage MIPS pipeline, directly upstream of the MEM/WB register.

---
 rtl/dm_stage_if.sv | 25 ++
 rtl/dm_stage.sv | 129 ++++++++++++
 tb/tb_dm_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_stage_if.sv
// Data-memory stage bus: M-stage access request in, raw read data,
// address-error flags and zero-fill Busy out.
//   master: MemReadM, MemWriteM, LsM, AddrM, WriteDataM -> ; <- ReadDataM, AdELM, AdESM, Busy
//   slave : the mirror image, used by dm_stage
interface dm_stage_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  LsM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        AdELM;
    logic        AdESM;
    logic        Busy;

    modport master (
        output MemReadM, MemWriteM, LsM, AddrM, WriteDataM,
        input  ReadDataM, AdELM, AdESM, Busy
    );

    modport slave (
        input  MemReadM, MemWriteM, LsM, AddrM, WriteDataM,
        output ReadDataM, AdELM, AdESM, Busy
    );
endinterface

// File: rtl/dm_stage.sv
// Data-memory stage: byte-lane stores, raw async word reads, AdEL/AdES,
// post-reset zero-fill FSM holding Busy.
//   Clk, Reset_n (async, active-low); bus : dm_stage_if.slave
module dm_stage #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic       Clk,
    input  logic       Reset_n,
    dm_stage_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
    logic                  w_busy;

    logic [31:0]           r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_out_range;
    logic                  w_word;
    logic                  w_half;
    logic                  w_byte;
    logic                  w_misalign;
    logic                  w_bad;
    logic                  w_store;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_busy        = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                w_busy        = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    assign w_idx       = bus.AddrM[ADDR_WIDTH+1:2];
    // Any set bit above the array's byte range means out of range.
    assign w_out_range = |bus.AddrM[31:ADDR_WIDTH+2];

    always_comb begin
        w_word = 1'b0;
        w_half = 1'b0;
        w_byte = 1'b0;
        unique case (bus.LsM)
            3'b001, 3'b010: w_half = 1'b1;
            3'b011, 3'b100: w_byte = 1'b1;
            default:        w_word = 1'b1;
        endcase
    end

    assign w_misalign = (w_word & (|bus.AddrM[1:0]))
                      | (w_half & bus.AddrM[0]);
    assign w_bad      = w_misalign | w_out_range;

    assign bus.AdELM  = !w_busy & bus.MemReadM & w_bad;
    assign bus.AdESM  = !w_busy & bus.MemWriteM & w_bad;
    assign w_store    = !w_busy & bus.MemWriteM & !w_bad;

    // Store data is replicated across lanes; the enables pick the lane.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.WriteDataM;
        unique case (1'b1)
            w_half: begin
                w_be    = bus.AddrM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.WriteDataM[15:0]}};
            end
            w_byte: begin
                w_be    = 4'b0001 << bus.AddrM[1:0];
                w_wdata = {4{bus.WriteDataM[7:0]}};
            end
            w_word: begin
                w_be    = 4'b1111;
                w_wdata = bus.WriteDataM;
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.WriteDataM;
            end
        endcase
    end

    // Array has no reset; the CLEAR sweep defines its contents.
    always_ff @(posedge Clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign bus.ReadDataM = (w_busy | w_out_range) ? 32'h0 : r_mem[w_idx];
    assign bus.Busy      = w_busy;

endmodule

// File: tb/tb_dm_stage.sv
// Directed bench for dm_stage: zero-fill timing, stores, loads,
// address errors and reset during the fill.
module tb_dm_stage;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_busy;
    logic [31:0] acc;

    dm_stage_if bus ();

    dm_stage #(.ADDR_WIDTH(AW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h",
                    tag, obs, exp);
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [2:0] ls, input logic [31:0] a,
                         input logic [31:0] d);
        bus.MemReadM   = rd;
        bus.MemWriteM  = wr;
        bus.LsM        = ls;
        bus.AddrM      = a;
        bus.WriteDataM = d;
    endtask

    // Counts posedges until Busy drops; write enable released after drop_at.
    task automatic wait_clear(output int n, input int drop_at);
        bit done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 2 * DEPTH && !done; i++) begin
            @(posedge Clk);
            #1;
            n++;
            if (n == drop_at) bus.MemWriteM = 1'b0;
            if (!bus.Busy) done = 1'b1;
        end
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] v);
        drive(1'b0, 1'b0, 3'b000, a, 32'h0);
        #1;
        v = bus.ReadDataM;
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'b000, 32'h1, 32'h0);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_busy", {31'h0, bus.Busy}, 32'h1);
        chk("rst_rdata", bus.ReadDataM, 32'h0);
        chk("rst_adel", {31'h0, bus.AdELM}, 32'h0);

        Reset_n = 1'b1;
        drive(1'b0, 1'b1, 3'b000, 32'h2, 32'h0);
        #1;
        chk("busy_ades_forced", {31'h0, bus.AdESM}, 32'h0);
        bus.MemWriteM = 1'b0;
        wait_clear(n_busy, 0);
        chk("busy_len", n_busy, DEPTH);

        @(negedge Clk);
        acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] v;
            read_word(32'(i * 4), v);
            acc = acc | v;
        end
        chk("clear_all_zero", acc, 32'h0);

        @(negedge Clk);
        drive(1'b0, 1'b1, 3'b000, 32'h10, 32'h12345678);
        #1;
        chk("sw_old_word", bus.ReadDataM, 32'h0);
        chk("sw_ades", {31'h0, bus.AdESM}, 32'h0);
        @(negedge Clk);
        drive(1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
        #1;
        chk("lw_data", bus.ReadDataM, 32'h12345678);
        chk("lw_adel", {31'h0, bus.AdELM}, 32'h0);

        @(negedge Clk);
        drive(1'b0, 1'b1, 3'b011, 32'h11, 32'hFFFFFFAB);
        @(negedge Clk);
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
        #1;
        chk("sb_lane1", bus.ReadDataM, 32'h1234AB78);
        @(negedge Clk);
        drive(1'b0, 1'b1, 3'b010, 32'h12, 32'h5555BEEF);
        @(negedge Clk);
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
        #1;
        chk("sh_upper", bus.ReadDataM, 32'hBEEFAB78);

        @(negedge Clk);
        drive(1'b0, 1'b1, 3'b000, 32'h12, 32'hDEADBEEF);
        #1;
        chk("sw_misalign_ades", {31'h0, bus.AdESM}, 32'h1);
        @(negedge Clk);
        drive(1'b0, 1'b1, 3'b001, 32'h11, 32'hDEADBEEF);
        #1;
        chk("sh_odd_ades", {31'h0, bus.AdESM}, 32'h1);
        @(negedge Clk);
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
        #1;
        chk("faulting_no_write", bus.ReadDataM, 32'hBEEFAB78);
        drive(1'b1, 1'b0, 3'b001, 32'h13, 32'h0);
        #1;
        chk("lh_odd_adel", {31'h0, bus.AdELM}, 32'h1);
        drive(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        #1;
        chk("lb_odd_ok", {31'h0, bus.AdELM}, 32'h0);
        chk("lb_raw_word", bus.ReadDataM, 32'hBEEFAB78);

        @(negedge Clk);
        drive(1'b0, 1'b1, 3'b100, 32'h10, 32'h000000CC);
        @(negedge Clk);
        drive(1'b0, 1'b1, 3'b001, 32'h10, 32'hAAAA1111);
        @(negedge Clk);
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
        #1;
        chk("sb0_sh0", bus.ReadDataM, 32'hBEEF1111);

        drive(1'b0, 1'b1, 3'b000, 32'(DEPTH * 4), 32'hFFFFFFFF);
        #1;
        chk("sw_oor_ades", {31'h0, bus.AdESM}, 32'h1);
        @(negedge Clk);
        drive(1'b1, 1'b0, 3'b000, 32'(DEPTH * 4), 32'h0);
        #1;
        chk("lw_oor_adel", {31'h0, bus.AdELM}, 32'h1);
        chk("lw_oor_zero", bus.ReadDataM, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("oor_no_alias_write", bus.ReadDataM, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h80000010, 32'h0);
        #1;
        chk("hi_bit_adel", {31'h0, bus.AdELM}, 32'h1);

        @(negedge Clk);
        drive(1'b0, 1'b1, 3'b000, 32'(DEPTH * 4 - 4), 32'hA5A5C3C3);
        #1;
        chk("top_sw_ok", {31'h0, bus.AdESM}, 32'h0);
        @(negedge Clk);
        drive(1'b0, 1'b0, 3'b000, 32'(DEPTH * 4 - 4), 32'h0);
        #1;
        chk("top_word", bus.ReadDataM, 32'hA5A5C3C3);

        drive(1'b1, 1'b1, 3'b000, 32'h21, 32'h0);
        #1;
        chk("rdwr_adel", {31'h0, bus.AdELM}, 32'h1);
        chk("rdwr_ades", {31'h0, bus.AdESM}, 32'h1);
        @(negedge Clk);
        drive(1'b1, 1'b1, 3'b000, 32'h20, 32'h0BADF00D);
        @(negedge Clk);
        drive(1'b0, 1'b0, 3'b000, 32'h20, 32'h0);
        #1;
        chk("rdwr_store", bus.ReadDataM, 32'h0BADF00D);

        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("midclr_busy", {31'h0, bus.Busy}, 32'h1);
        chk("midclr_rdata", bus.ReadDataM, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        drive(1'b0, 1'b1, 3'b000, 32'h24, 32'hCAFEF00D);
        wait_clear(n_busy, 40);
        chk("restart_len", n_busy, DEPTH);
        @(negedge Clk);
        drive(1'b0, 1'b0, 3'b000, 32'h24, 32'h0);
        #1;
        chk("busy_store_dropped", bus.ReadDataM, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
        #1;
        chk("recleared", bus.ReadDataM, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
